// File: rtl/arb_pkg.sv
// Shared arbiter definitions: default sizing and the index-width helper.
package arb_pkg;

   localparam int ARB_N_DEF  = 8;
   localparam int ARB_WW_DEF = 4;

   function automatic int arb_iw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Circular find-first: rotate requests so i_ptr sits at bit 0, pick the lowest
// set bit with fixed priority, then rotate the result back to absolute indices.
module arb_rr_pick
   import arb_pkg::*;
#(
   parameter int N  = ARB_N_DEF,
   parameter int IW = arb_iw(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   logic [N-1:0] w_rot;
   logic         w_found;
   int           w_k;

   // Modular add that wraps at N rather than at 2^IW.
   function automatic int wrap_add(input int a, input int b);
      int s;
      s = a + b;
      return (s >= N) ? (s - N) : s;
   endfunction

   always_comb begin
      w_rot = '0;
      for (int k = 0; k < N; k++) begin
         w_rot[k] = i_req[wrap_add(k, int'(i_ptr))];
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_k     = 0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_k     = k;
         end
      end
   end

   always_comb begin
      o_found = w_found;
      o_idx   = w_found ? IW'(wrap_add(w_k, int'(i_ptr))) : '0;
      o_gnt   = w_found ? (N'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/arb_rr_weighted.sv
// Work-conserving round-robin arbiter with weighted tenure: the owner keeps the
// grant for up to its latched weight in cycles (or indefinitely under hold).
module arb_rr_weighted
   import arb_pkg::*;
#(
   parameter int N  = ARB_N_DEF,
   parameter int WW = ARB_WW_DEF,
   parameter int IW = arb_iw(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] weight,
   input  logic            hold,
   output logic [N-1:0]    gnt,
   output logic [IW-1:0]   gnt_id,
   output logic            gnt_vld
);

   logic [N-1:0]  r_gnt;
   logic [IW-1:0] r_gnt_id;
   logic          r_gnt_vld;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_owner;
   logic [WW-1:0] r_cnt;
   logic [WW-1:0] r_wt;

   logic [N-1:0]  w_pick_gnt;
   logic [IW-1:0] w_pick_idx;
   logic          w_pick_found;
   logic          w_keep;
   logic [WW-1:0] w_wfield;
   logic [WW-1:0] w_wt_new;
   logic [IW-1:0] w_ptr_nxt;
   logic [WW-1:0] w_cnt_inc;

   arb_rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   // r_wt is never 0, so r_wt - 1 cannot underflow.
   assign w_keep    = r_gnt_vld && req[r_owner] && (hold || (r_cnt < (r_wt - WW'(1))));
   assign w_wfield  = weight[int'(w_pick_idx)*WW +: WW];
   assign w_wt_new  = (w_wfield == '0) ? WW'(1) : w_wfield;
   assign w_ptr_nxt = (int'(w_pick_idx) == N - 1) ? '0 : (w_pick_idx + IW'(1));
   assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + WW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_gnt_vld <= 1'b0;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_cnt     <= '0;
         r_wt      <= WW'(1);
      end else if (w_keep) begin
         r_cnt <= w_cnt_inc;
      end else if (w_pick_found) begin
         r_gnt     <= w_pick_gnt;
         r_gnt_id  <= w_pick_idx;
         r_gnt_vld <= 1'b1;
         r_owner   <= w_pick_idx;
         r_cnt     <= '0;
         r_wt      <= w_wt_new;
         r_ptr     <= w_ptr_nxt;
      end else begin
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_gnt_vld <= 1'b0;
         r_owner   <= '0;
         r_cnt     <= '0;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_arb_rr_weighted.sv
// Bench for arb_rr_weighted: directed scenarios plus random traffic on an N=8
// and an N=5 instance, both compared cycle by cycle against a tenure model.
module tb_arb_rr_weighted;

   localparam int N   = 8;
   localparam int WW  = 4;
   localparam int IW  = 3;
   localparam int N5  = 5;
   localparam int IW5 = 3;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req   = '0;
   logic [N*WW-1:0]  weight = '0;
   logic             hold  = 1'b0;
   logic [N-1:0]     gnt;
   logic [IW-1:0]    gnt_id;
   logic             gnt_vld;

   logic [N5-1:0]    req5   = '0;
   logic [N5*WW-1:0] weight5 = '0;
   logic             hold5  = 1'b0;
   logic [N5-1:0]    gnt5;
   logic [IW5-1:0]   gnt_id5;
   logic             gnt_vld5;

   arb_rr_weighted #(.N(N), .WW(WW), .IW(IW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .weight  (weight),
      .hold    (hold),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld)
   );

   arb_rr_weighted #(.N(N5), .WW(WW), .IW(IW5)) dut5 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req5),
      .weight  (weight5),
      .hold    (hold5),
      .gnt     (gnt5),
      .gnt_id  (gnt_id5),
      .gnt_vld (gnt_vld5)
   );

   always #5 clk = ~clk;

   // owner = -1 means idle; used = cycles granted so far in the current tenure
   typedef struct {
      int owner;
      int ptr;
      int used;
      int wt;
   } mst_t;

   mst_t m8;
   mst_t m5;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic mst_t m_reset();
      mst_t r;
      r.owner = -1;
      r.ptr   = 0;
      r.used  = 0;
      r.wt    = 1;
      return r;
   endfunction

   function automatic mst_t m_step(input mst_t s, input int n, input logic [31:0] rq,
                                   input logic [127:0] wts, input logic hld);
      mst_t r;
      int   f;
      r = s;
      if (s.owner >= 0 && rq[s.owner] && (hld || s.used < s.wt)) begin
         r.used = s.used + 1;
         return r;
      end
      for (int k = 0; k < n; k++) begin
         int i;
         i = (s.ptr + k) % n;
         if (rq[i]) begin
            f = 0;
            for (int b = 0; b < WW; b++) f = f | (int'(wts[i*WW + b]) << b);
            r.owner = i;
            r.used  = 1;
            r.wt    = (f == 0) ? 1 : f;
            r.ptr   = (i + 1) % n;
            return r;
         end
      end
      r.owner = -1;
      r.used  = 0;
      return r;
   endfunction

   task automatic compare_all(input string ph);
      logic [31:0] eg;
      logic [31:0] ei;
      eg = (m8.owner >= 0) ? (32'd1 << m8.owner) : 32'd0;
      ei = (m8.owner >= 0) ? 32'(m8.owner) : 32'd0;
      check_eq({ph, ".gnt"},     32'(gnt),     eg);
      check_eq({ph, ".gnt_id"},  32'(gnt_id),  ei);
      check_eq({ph, ".gnt_vld"}, 32'(gnt_vld), 32'(m8.owner >= 0));
      eg = (m5.owner >= 0) ? (32'd1 << m5.owner) : 32'd0;
      ei = (m5.owner >= 0) ? 32'(m5.owner) : 32'd0;
      check_eq({ph, ".gnt5"},     32'(gnt5),     eg);
      check_eq({ph, ".gnt_id5"},  32'(gnt_id5),  ei);
      check_eq({ph, ".gnt_vld5"}, 32'(gnt_vld5), 32'(m5.owner >= 0));
   endtask

   // Inputs are already set for the coming rising edge; advance models, then check.
   task automatic tick(input string ph);
      m8 = m_step(m8, N,  32'(req),  128'(weight),  hold);
      m5 = m_step(m5, N5, 32'(req5), 128'(weight5), hold5);
      @(negedge clk);
      compare_all(ph);
   endtask

   task automatic set_w(input int i, input int v);
      weight[i*WW +: WW] = WW'(v);
   endtask

   initial begin
      m8 = m_reset();
      m5 = m_reset();
      #2;
      compare_all("reset");
      @(negedge clk);
      compare_all("reset_held");
      rst_n = 1'b1;

      // All weights 1, everyone requesting: strict rotation.
      for (int i = 0; i < N; i++) set_w(i, 1);
      req  = 8'hFF;
      req5 = 5'b10001;
      for (int c = 0; c < 10; c++) tick("rr_all");

      // Weights 3 and 2 on requesters 2 and 5.
      set_w(2, 3);
      set_w(5, 2);
      req = 8'h24;
      for (int c = 0; c < 15; c++) tick("weighted");

      // Idle, then requester 3 alone under hold.
      req = 8'h00;
      tick("idle");
      hold = 1'b1;
      tick("hold_idle");
      set_w(3, 2);
      req = 8'h08;
      for (int c = 0; c < 20; c++) tick("hold");
      hold = 1'b0;
      req  = 8'h0A;
      tick("hold_drop");
      tick("hold_after");

      // Weight change mid-tenure must not alter the current tenure.
      req = 8'h00;
      tick("idle2");
      set_w(6, 4);
      req = 8'h40;
      tick("own6");
      set_w(6, 1);
      tick("own6_wchg");
      req = 8'h41;
      tick("own6_pend");
      req = 8'h01;
      tick("own6_drop");
      tick("own0");

      // Asynchronous reset mid-tenure, then a lone request from 7.
      set_w(6, 4);
      req = 8'h40;
      tick("pre_rst");
      tick("pre_rst2");
      #2 rst_n = 1'b0;
      m8 = m_reset();
      m5 = m_reset();
      #1 compare_all("async_rst");
      req = 8'h80;
      set_w(7, 1);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) tick("post_rst");

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         req   = N'($urandom);
         req5  = N5'($urandom);
         hold  = ($urandom_range(0, 5) == 0);
         hold5 = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) weight  = (N*WW)'({$urandom, $urandom});
         if ($urandom_range(0, 7) == 0) weight5 = (N5*WW)'($urandom);
         if ($urandom_range(0, 3) == 0 && m8.owner >= 0) req[m8.owner] = 1'b1;
         tick("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arb_rr_weighted.md
ARB_RR_WEIGHTED -- requirements
Module: arb_rr_weighted

Interface
REQ-001 Parameter N, default 8: number of requesters; legal range 2..32, non-power-of-two allowed.
REQ-002 Parameter WW, default 4: width of each per-requester weight field.
REQ-003 Parameter IW, default $clog2(N): width of gnt_id.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N  request vector; bit i = requester i.
REQ-007 weight  input  N*WW  packed weights; field i = weight[i*WW +: WW] = max consecutive grant cycles for requester i; value 0 treated as 1.
REQ-008 hold  input  1  while high, the current owner keeps the grant regardless of weight expiry.
REQ-009 gnt  output  N  registered one-hot grant; all zero when idle.
REQ-010 gnt_id  output  IW  registered binary index of the owner; 0 when idle.
REQ-011 gnt_vld  output  1  registered; high iff gnt is non-zero.

Function
REQ-012 The block SHALL be a work-conserving round-robin arbiter with weighted tenure; latency from req assertion (idle arbiter) to gnt = 1 cycle.
REQ-013 State: ptr (IW bits, highest-priority index), owner (IW bits), cnt (WW bits, cycles already granted in current tenure), wt (WW bits, weight latched at tenure start).
REQ-014 Keep condition each cycle: gnt_vld && req[owner] && (hold || cnt < wt-1); when true gnt, gnt_id unchanged and cnt increments, saturating at all-ones.
REQ-015 Otherwise the block SHALL arbitrate: winner = first set bit of req scanning circularly ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-016 On a win at index i: next gnt = one-hot i, gnt_id = i, cnt = 0, wt = max(weight field i, 1), ptr = (i+1) mod N (wrap at N, not 2^IW).
REQ-017 If arbitration finds no request: gnt = 0, gnt_vld = 0, gnt_id = 0, ptr unchanged.
REQ-018 Tenure end and next grant SHALL occur in the same cycle; no idle bubble between owners when another request is pending.
REQ-019 Owner dropping req ends tenure immediately: gnt deasserts (or switches) on the next edge.
REQ-020 Expired owner still requesting with no other requester SHALL be re-granted for a fresh tenure (cnt = 0, weight re-latched).
REQ-021 Weight changes during a tenure SHALL NOT affect it; only the value sampled at tenure start applies.
REQ-022 hold asserted while idle has no effect; hold deasserting after cnt >= wt-1 ends the tenure at that cycle's evaluation.
REQ-023 gnt SHALL be one-hot or zero in every cycle; gnt_id SHALL equal the index of the set gnt bit.

Reset
REQ-024 rst_n low SHALL asynchronously force gnt = 0, gnt_id = 0, gnt_vld = 0, ptr = 0, owner = 0, cnt = 0, wt = 1.
REQ-025 Reset asserted mid-tenure SHALL abort it; first arbitration after release starts from ptr = 0.
REQ-026 Outputs SHALL be driven only from registers; no combinational path from req to gnt.

Structure
REQ-027 Shared package arb_pkg SHALL hold the default N, WW and a function computing IW.
REQ-028 Circular find-first (req, ptr -> one-hot, index, found) SHALL be a sub-module arb_rr_pick (rotate, fixed priority, rotate back), reusable by other arbiters.
REQ-029 The top SHALL contain only tenure control (keep logic, counters, ptr update) and output registers.

Verification
REQ-030 N=8, all weights 1, req=8'hFF constant -> gnt cycles 01,02,04,...,80,01 each for 1 cycle, gnt_vld continuously high.
REQ-031 N=8, weight[2]=3, weight[5]=2, req=8'h24 constant -> gnt 04,04,04,20,20,04,... repeating.
REQ-032 N=5, weight all 1, req=5'b10001, ptr at 4 -> grants 4 then 0 then 4 (wrap at 5, gnt_id never 5..7).
REQ-033 N=8, req[3] only, weight[3]=2, hold high 6 cycles -> gnt=08 for 6 cycles, cnt saturation free of glitches; hold low with req[1] up -> gnt=02 next cycle.
REQ-034 Owner 6 drops req mid-tenure (weight 4, cycle 2) with req[0] pending -> gnt=01 next edge, no zero cycle.
REQ-035 rst_n pulsed low mid-tenure (asynchronous to clk) -> gnt=0 immediately; after release req=8'h80 -> gnt=80 one cycle later, ptr=0 then 0 after wrap.
